demux1to2_32bit_buffered: RTL and testbench

- Routes one 32-bit producer stream to one of two consumer streams, chosen per word by SELECT. This is the one-to-two counterpart of the datapath's 2:1 select mux.
- Each output has a small FIFO, so one stalled consumer does not block words destined for the other once that word has been accepted.
- Used in the RV32IM FPGA pipeline to route memory/bus read data to either the fetch side (OUT1) or the load/store side (OUT2).

---
 rtl/demux1to2_32bit_buffered_pkg.sv | 26 ++
 rtl/fifo_32bit_sync.sv | 68 ++++++
 rtl/demux1to2_32bit_buffered.sv | 107 ++++++++++
 tb/tb_demux1to2_32bit_buffered.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux1to2_32bit_buffered_pkg.sv
// Shared constants and FIFO occupancy helpers for the 1:2 buffered demux.
// Used by fifo_32bit_sync and demux1to2_32bit_buffered.
package demux1to2_32bit_buffered_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 2;

    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

    typedef enum logic [1:0] {
        FifoEmpty,
        FifoPartial,
        FifoFull
    } fifo_state_e;

    function automatic fifo_state_e fifo_state(input int unsigned count, input int unsigned depth);
        if (count == 0) begin
            return FifoEmpty;
        end else if (count >= depth) begin
            return FifoFull;
        end
        return FifoPartial;
    endfunction

endpackage

// File: rtl/fifo_32bit_sync.sv
// Small synchronous FIFO with a registered head word; one per demux output.
// The head keeps showing the last popped word while the FIFO is empty.
module fifo_32bit_sync
    import demux1to2_32bit_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    head_ptr;
    logic [CW-1:0]    count_q;
    fifo_state_e      state;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        state = fifo_state(32'(count_q), DEPTH);
    end

    assign full    = (state == FifoFull);
    assign empty   = (state == FifoEmpty);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // When empty, the slot behind rd_ptr still holds the last popped word.
    assign head_ptr = empty ? (rd_ptr_q - PW'(1)) : rd_ptr_q;
    assign head     = mem_q[head_ptr];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/demux1to2_32bit_buffered.sv
// Routes one valid/ready stream to OUT1 or OUT2 by SELECT, each output buffered by a FIFO.
// Define DEMUX1TO2_COUNT_EN to add pop counters (COUNT1/COUNT2) and a stall counter (STALL_CNT).
module demux1to2_32bit_buffered
    import demux1to2_32bit_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] INPUT,
    input  logic             SELECT,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] RESULT1,
    output logic             VALID1,
    input  logic             READY1,
    output logic [WIDTH-1:0] RESULT2,
    output logic             VALID2,
    input  logic             READY2
`ifdef DEMUX1TO2_COUNT_EN
    ,
    output logic [31:0]      COUNT1,
    output logic [31:0]      COUNT2,
    output logic [31:0]      STALL_CNT
`endif
);

    logic full1, empty1, full2, empty2;
    logic sel_full;
    logic accept, push1, push2, pop1, pop2;
    logic out_of_reset_q;

    // Keeps IN_READY low while RESET is asserted without feeding RESET into the datapath.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_of_reset_q <= 1'b0;
        end else begin
            out_of_reset_q <= 1'b1;
        end
    end

    assign sel_full = (SELECT == SEL_OUT2) ? full2 : full1;
    assign IN_READY = out_of_reset_q & ~sel_full;
    assign accept   = IN_VALID & IN_READY;
    assign push1    = accept & (SELECT == SEL_OUT1);
    assign push2    = accept & (SELECT == SEL_OUT2);
    assign VALID1   = ~empty1;
    assign VALID2   = ~empty2;
    assign pop1     = VALID1 & READY1;
    assign pop2     = VALID2 & READY2;

    fifo_32bit_sync #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo1 (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (push1),
        .push_data(INPUT),
        .pop      (pop1),
        .full     (full1),
        .empty    (empty1),
        .head     (RESULT1)
    );

    fifo_32bit_sync #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo2 (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (push2),
        .push_data(INPUT),
        .pop      (pop2),
        .full     (full2),
        .empty    (empty2),
        .head     (RESULT2)
    );

`ifdef DEMUX1TO2_COUNT_EN
    logic [31:0] count1_q, count2_q, stall_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count1_q <= '0;
            count2_q <= '0;
            stall_q  <= '0;
        end else begin
            if (pop1) begin
                count1_q <= count1_q + 32'd1;
            end
            if (pop2) begin
                count2_q <= count2_q + 32'd1;
            end
            if (IN_VALID && !IN_READY) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign COUNT1    = count1_q;
    assign COUNT2    = count2_q;
    assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_demux1to2_32bit_buffered.sv
// Directed and scoreboard-driven bench for demux1to2_32bit_buffered (DEPTH=2).
// Honours DEMUX1TO2_COUNT_EN when the design is built with the counters.
module tb_demux1to2_32bit_buffered;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic        sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res1, res2;
    logic        v1, v2, rdy1, rdy2;
`ifdef DEMUX1TO2_COUNT_EN
    logic [31:0] cnt1, cnt2, stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    demux1to2_32bit_buffered #(
        .WIDTH(32),
        .DEPTH(2)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .INPUT    (din),
        .SELECT   (sel),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .RESULT1  (res1),
        .VALID1   (v1),
        .READY1   (rdy1),
        .RESULT2  (res2),
        .VALID2   (v2),
        .READY2   (rdy2)
`ifdef DEMUX1TO2_COUNT_EN
        ,
        .COUNT1   (cnt1),
        .COUNT2   (cnt2),
        .STALL_CNT(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; sel = 1'b0; din = 32'hCAFEF00D;
        rdy1 = 1'b0; rdy2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0h want 0", in_ready); end
        n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL rst_v1: got %0h want 0", v1); end
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL rst_v2: got %0h want 0", v2); end
        n_cmp++; if (res1 !== 32'h0) begin n_err++; $display("FAIL rst_res1: got %h want 0", res1); end
        n_cmp++; if (res2 !== 32'h0) begin n_err++; $display("FAIL rst_res2: got %h want 0", res2); end
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready: got %0h want 1", in_ready); end
        n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL rel_v1: got %0h want 0", v1); end
    endtask

    task automatic test_routing();
        rdy1 = 1'b1; rdy2 = 1'b1;
        din = 32'hDEADBEEF; sel = 1'b0; in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rt_ready: got %0h want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (v1 !== 1'b1) begin n_err++; $display("FAIL rt_v1: got %0h want 1", v1); end
        n_cmp++; if (res1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rt_res1: got %h want deadbeef", res1); end
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL rt_v2_idle: got %0h want 0", v2); end
        din = 32'h12345678; sel = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL rt_v2: got %0h want 1", v2); end
        n_cmp++; if (res2 !== 32'h12345678) begin n_err++; $display("FAIL rt_res2: got %h want 12345678", res2); end
        n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL rt_v1_drop: got %0h want 0", v1); end
        n_cmp++; if (res1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rt_res1_hold: got %h want deadbeef", res1); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL rt_v2_drop: got %0h want 0", v2); end
        n_cmp++; if (res2 !== 32'h12345678) begin n_err++; $display("FAIL rt_res2_hold: got %h want 12345678", res2); end
    endtask

    task automatic test_backpressure();
        rdy1 = 1'b0; rdy2 = 1'b1;
        sel = 1'b0; in_valid = 1'b1; din = 32'hA0000001;
        @(posedge clk); #1;
        din = 32'hA0000002;
        @(posedge clk); #1;
        din = 32'hA0000003;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %0h want 0", in_ready); end
        n_cmp++; if (v1 !== 1'b1) begin n_err++; $display("FAIL bp_v1: got %0h want 1", v1); end
        n_cmp++; if (res1 !== 32'hA0000001) begin n_err++; $display("FAIL bp_head: got %h want a0000001", res1); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full2: got %0h want 0", in_ready); end
        n_cmp++; if (res1 !== 32'hA0000001) begin n_err++; $display("FAIL bp_stable: got %h want a0000001", res1); end
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL bp_v2_idle: got %0h want 0", v2); end
        sel = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_retarget: got %0h want 1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL bp_v2: got %0h want 1", v2); end
        n_cmp++; if (res2 !== 32'hA0000003) begin n_err++; $display("FAIL bp_res2: got %h want a0000003", res2); end
        // Consumer pops a full FIFO: no pass-through, so the producer still stalls.
        sel = 1'b0; din = 32'hA0000004; rdy1 = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_no_pass: got %0h want 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (res1 !== 32'hA0000002) begin n_err++; $display("FAIL bp_next: got %h want a0000002", res1); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %0h want 0", v1); end
    endtask

    task automatic test_push_pop();
        logic [31:0] q1[$];
        logic [31:0] q2[$];
        int sent = 0;
        int cyc = 0;
        bit exp_rdy, acc, p1, p2;
        while ((sent < 100 || q1.size() != 0) && cyc < 1000) begin
            in_valid = (sent < 100); sel = 1'b0; din = 32'(sent);
            rdy1 = (cyc != 0); rdy2 = 1'b1;
            #1;
            exp_rdy = (q1.size() < 2);
            n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL pp_ready c%0d: got %0h want %0h", cyc, in_ready, exp_rdy); end
            n_cmp++; if (v1 !== (q1.size() != 0)) begin n_err++; $display("FAIL pp_v1 c%0d: got %0h want %0h", cyc, v1, q1.size() != 0); end
            if (q1.size() != 0) begin
                n_cmp++; if (res1 !== q1[0]) begin n_err++; $display("FAIL pp_res1 c%0d: got %h want %h", cyc, res1, q1[0]); end
            end
            acc = in_valid && exp_rdy;
            p1 = (q1.size() != 0) && rdy1;
            p2 = (q2.size() != 0) && rdy2;
            @(posedge clk);
            if (p1) void'(q1.pop_front());
            if (p2) void'(q2.pop_front());
            if (acc) begin q1.push_back(din); sent++; end
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++; if (cyc >= 1000) begin n_err++; $display("FAIL pp_timeout: got %0d cycles want <1000", cyc); end
    endtask

    task automatic test_wrap();
        logic [31:0] q1[$];
        logic [31:0] q2[$];
        int sent = 0;
        int cyc = 0;
        bit exp_rdy, acc, p1, p2;
        while ((sent < 1000 || q1.size() != 0 || q2.size() != 0) && cyc < 20000) begin
            in_valid = (sent < 1000) && ($urandom_range(3) != 0);
            sel = 1'($urandom_range(1));
            din = 32'h5A000000 + 32'(sent);
            rdy1 = 1'($urandom_range(1)); rdy2 = 1'($urandom_range(1));
            #1;
            exp_rdy = sel ? (q2.size() < 2) : (q1.size() < 2);
            n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL wr_ready c%0d: got %0h want %0h", cyc, in_ready, exp_rdy); end
            n_cmp++; if (v1 !== (q1.size() != 0)) begin n_err++; $display("FAIL wr_v1 c%0d: got %0h want %0h", cyc, v1, q1.size() != 0); end
            n_cmp++; if (v2 !== (q2.size() != 0)) begin n_err++; $display("FAIL wr_v2 c%0d: got %0h want %0h", cyc, v2, q2.size() != 0); end
            if (q1.size() != 0) begin
                n_cmp++; if (res1 !== q1[0]) begin n_err++; $display("FAIL wr_res1 c%0d: got %h want %h", cyc, res1, q1[0]); end
            end
            if (q2.size() != 0) begin
                n_cmp++; if (res2 !== q2[0]) begin n_err++; $display("FAIL wr_res2 c%0d: got %h want %h", cyc, res2, q2[0]); end
            end
            acc = in_valid && exp_rdy;
            p1 = (q1.size() != 0) && rdy1;
            p2 = (q2.size() != 0) && rdy2;
            @(posedge clk);
            if (p1) void'(q1.pop_front());
            if (p2) void'(q2.pop_front());
            if (acc) begin
                if (sel) q2.push_back(din);
                else     q1.push_back(din);
                sent++;
            end
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++; if (cyc >= 20000) begin n_err++; $display("FAIL wr_timeout: got %0d cycles want <20000", cyc); end
    endtask

    task automatic test_reset_mid();
        rdy1 = 1'b0; rdy2 = 1'b0; in_valid = 1'b1;
        sel = 1'b0; din = 32'hB0000001; @(posedge clk); #1;
        din = 32'hB0000002;               @(posedge clk); #1;
        sel = 1'b1; din = 32'hC0000001; @(posedge clk); #1;
        din = 32'hC0000002;               @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_full: got %0h want 0", in_ready); end
        n_cmp++; if (v1 !== 1'b1) begin n_err++; $display("FAIL rm_v1_pre: got %0h want 1", v1); end
        n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL rm_v2_pre: got %0h want 1", v2); end
        n_cmp++; if (res2 !== 32'hC0000001) begin n_err++; $display("FAIL rm_res2_pre: got %h want c0000001", res2); end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL rm_v1_async: got %0h want 0", v1); end
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL rm_v2_async: got %0h want 0", v2); end
        n_cmp++; if (res1 !== 32'h0) begin n_err++; $display("FAIL rm_res1: got %h want 0", res1); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready: got %0h want 0", in_ready); end
`ifdef DEMUX1TO2_COUNT_EN
        n_cmp++; if (cnt1 !== 32'h0) begin n_err++; $display("FAIL rm_cnt1: got %0d want 0", cnt1); end
        n_cmp++; if (cnt2 !== 32'h0) begin n_err++; $display("FAIL rm_cnt2: got %0d want 0", cnt2); end
        n_cmp++; if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL rm_stall: got %0d want 0", stall_cnt); end
`endif
        @(posedge clk); #2;
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready2: got %0h want 1", in_ready); end
        sel = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready1: got %0h want 1", in_ready); end
        n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL rm_v1_post: got %0h want 0", v1); end
        n_cmp++; if (v2 !== 1'b0) begin n_err++; $display("FAIL rm_v2_post: got %0h want 0", v2); end
`ifdef DEMUX1TO2_COUNT_EN
        rdy1 = 1'b1; in_valid = 1'b1; din = 32'hD0000001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (cnt1 !== 32'd1) begin n_err++; $display("FAIL rm_cnt1_one: got %0d want 1", cnt1); end
`endif
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_push_pop();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
